// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer and its helpers.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_HOLD      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_PWRDN     = 3'd4,
      ST_FAULT     = 3'd5
   } state_e;

   localparam int RETRY_W   = 8;
   localparam int RETRY_SAT = (2 ** RETRY_W) - 1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage flop synchronizer for a single level signal crossing into clk_i.
module sync_bit #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer on the raw board clock: pulses the PLL reset, qualifies lock,
// releases the downstream reset and re-sequences on lock loss or timeout.
//
// state     | meaning
// HOLD      | PLL reset asserted for RST_HOLD_CYCLES
// WAIT_LOCK | PLL reset released, waiting for synchronized lock
// STABLE    | counting consecutive locked cycles
// RUN       | clock usable, downstream reset released
// PWRDN     | PLL powered down while pwrdwn_req is high
// FAULT     | retries exhausted, parked until restart
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_HOLD_CYCLES     = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 16384,
   parameter int STABLE_CYCLES       = 256,
   parameter int MAX_RETRIES         = 7,
   parameter int SYNC_STAGES         = 2
) (
   input  logic               clkin,
   input  logic               reset_n,
   input  logic               pll_locked,
   input  logic               restart,
   input  logic               pwrdwn_req,
   output logic               pll_reset,
   output logic               pll_pwrdwn,
   output logic               sys_reset_n,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [2:0]         state_o
);

   localparam int CNT_W = $clog2(max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)) + 1;

   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_TOP    = RETRY_W'(RETRY_SAT);
   // A limit at or above saturation can never be exceeded, so FAULT is unreachable then.
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  =
      RETRY_W'((MAX_RETRIES > RETRY_SAT) ? RETRY_SAT : MAX_RETRIES);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
   logic               fail;
   logic               locked_s;

   logic pll_reset_q, pll_reset_d;
   logic pll_pwrdwn_q, pll_pwrdwn_d;
   logic sys_rst_n_q, sys_rst_n_d;
   logic ready_q, ready_d;
   logic fault_q, fault_d;

   sync_bit #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b0)
   ) u_sync_locked (
      .clk_i   (clkin),
      .rst_n_i (reset_n),
      .d_i     (pll_locked),
      .q_o     (locked_s)
   );

   assign retry_inc = (retry_q == RETRY_TOP) ? retry_q : retry_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      fail    = 1'b0;

      if (restart) begin
         retry_d = '0;
         cnt_d   = '0;
         state_d = pwrdwn_req ? ST_PWRDN : ST_HOLD;
      end else if (pwrdwn_req && (state_q != ST_FAULT)) begin
         if (state_q != ST_PWRDN) begin
            state_d = ST_PWRDN;
            cnt_d   = '0;
         end
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  fail = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_STABLE: begin
               // Any drop discards the partial window; the retry path starts over in HOLD.
               if (!locked_s) begin
                  fail = 1'b1;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  fail = 1'b1;
               end
            end
            ST_PWRDN: begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
            ST_FAULT: begin
            end
            default: begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         endcase

         if (fail) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc > RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
         end
      end
   end

   // Outputs are decoded from the next state so they register together with it.
   always_comb begin
      pll_reset_d  = 1'b0;
      pll_pwrdwn_d = 1'b0;
      sys_rst_n_d  = 1'b0;
      ready_d      = 1'b0;
      fault_d      = 1'b0;
      case (state_d)
         ST_HOLD: begin
            pll_reset_d = 1'b1;
         end
         ST_PWRDN: begin
            pll_reset_d  = 1'b1;
            pll_pwrdwn_d = 1'b1;
         end
         ST_FAULT: begin
            pll_reset_d = 1'b1;
            fault_d     = 1'b1;
         end
         ST_RUN: begin
            sys_rst_n_d = 1'b1;
            ready_d     = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_HOLD;
         cnt_q        <= '0;
         retry_q      <= '0;
         pll_reset_q  <= 1'b1;
         pll_pwrdwn_q <= 1'b0;
         sys_rst_n_q  <= 1'b0;
         ready_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         pll_reset_q  <= pll_reset_d;
         pll_pwrdwn_q <= pll_pwrdwn_d;
         sys_rst_n_q  <= sys_rst_n_d;
         ready_q      <= ready_d;
         fault_q      <= fault_d;
      end
   end

   assign pll_reset   = pll_reset_q;
   assign pll_pwrdwn  = pll_pwrdwn_q;
   assign sys_reset_n = sys_rst_n_q;
   assign ready       = ready_q;
   assign fault       = fault_q;
   assign retry_cnt   = retry_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: phase/elapsed-time reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized lock/restart/power-down.
module tb_pll_reset_sequencer;

   localparam int HOLD_C = 4;
   localparam int TMO_C  = 64;
   localparam int STB_C  = 8;
   localparam int MAXR   = 2;
   localparam int SYNC   = 2;

   localparam int P_HOLD   = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_RUN    = 3;
   localparam int P_PWRDN  = 4;
   localparam int P_FAULT  = 5;

   logic       clkin      = 1'b0;
   logic       reset_n    = 1'b0;
   logic       pll_locked = 1'b0;
   logic       restart    = 1'b0;
   logic       pwrdwn_req = 1'b0;
   logic       pll_reset, pll_pwrdwn, sys_reset_n, ready, fault;
   logic [7:0] retry_cnt;
   logic [2:0] state_o;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // reference model: current phase, cycles completed in it, failures since reset/restart
   int m_phase   = P_HOLD;
   int m_elapsed = 0;
   int m_fails   = 0;
   bit m_sync [SYNC];

   pll_reset_sequencer #(
      .RST_HOLD_CYCLES     (HOLD_C),
      .LOCK_TIMEOUT_CYCLES (TMO_C),
      .STABLE_CYCLES       (STB_C),
      .MAX_RETRIES         (MAXR),
      .SYNC_STAGES         (SYNC)
   ) dut (
      .clkin       (clkin),
      .reset_n     (reset_n),
      .pll_locked  (pll_locked),
      .restart     (restart),
      .pwrdwn_req  (pwrdwn_req),
      .pll_reset   (pll_reset),
      .pll_pwrdwn  (pll_pwrdwn),
      .sys_reset_n (sys_reset_n),
      .ready       (ready),
      .fault       (fault),
      .retry_cnt   (retry_cnt),
      .state_o     (state_o)
   );

   always #5 clkin = ~clkin;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void m_enter(input int p);
      m_phase   = p;
      m_elapsed = 0;
   endfunction

   function automatic void m_fail();
      if (m_fails < 255) m_fails++;
      m_enter((m_fails > MAXR) ? P_FAULT : P_HOLD);
   endfunction

   function automatic void m_step(input bit ls, input bit rs, input bit pd);
      if (rs) begin
         m_fails = 0;
         m_enter(pd ? P_PWRDN : P_HOLD);
      end else if (pd && m_phase != P_FAULT) begin
         if (m_phase != P_PWRDN) m_enter(P_PWRDN);
      end else begin
         case (m_phase)
            P_PWRDN: m_enter(P_HOLD);
            P_HOLD: begin
               m_elapsed++;
               if (m_elapsed == HOLD_C) m_enter(P_WAIT);
            end
            P_WAIT: begin
               if (ls) m_enter(P_STABLE);
               else begin
                  m_elapsed++;
                  if (m_elapsed == TMO_C) m_fail();
               end
            end
            P_STABLE: begin
               if (!ls) m_fail();
               else begin
                  m_elapsed++;
                  if (m_elapsed == STB_C) m_enter(P_RUN);
               end
            end
            P_RUN: if (!ls) m_fail();
            default: ;
         endcase
      end
   endfunction

   initial begin
      forever begin
         @(posedge clkin or negedge reset_n);
         if (!reset_n) begin
            m_enter(P_HOLD);
            m_fails = 0;
            for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
         end else begin
            m_step(m_sync[SYNC-1], restart, pwrdwn_req);
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = pll_locked;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clkin);
         if (chk_en) begin
            check("state_o", 32'(state_o), 32'(m_phase));
            check("pll_reset", 32'(pll_reset),
                  32'(m_phase == P_HOLD || m_phase == P_PWRDN || m_phase == P_FAULT));
            check("pll_pwrdwn", 32'(pll_pwrdwn), 32'(m_phase == P_PWRDN));
            check("sys_reset_n", 32'(sys_reset_n), 32'(m_phase == P_RUN));
            check("ready", 32'(ready), 32'(m_phase == P_RUN));
            check("fault", 32'(fault), 32'(m_phase == P_FAULT));
            check("retry_cnt", 32'(retry_cnt), 32'(m_fails));
         end
      end
   end

   task automatic wait_state(input int s, input int budget, output int cyc);
      cyc = -1;
      for (int i = 1; i <= budget && cyc < 0; i++) begin
         @(negedge clkin);
         if (state_o == 3'(s)) cyc = i;
      end
      if (cyc < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_state: state %0d not reached in %0d cycles, still %0d", s, budget, state_o);
      end
   endtask

   task automatic pulse_restart(input bit pd);
      @(negedge clkin);
      restart    = 1'b1;
      pwrdwn_req = pd;
      @(negedge clkin);
      restart = 1'b0;
   endtask

   initial begin
      #1000000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int n;
      int hold_left;

      // reset values
      repeat (3) @(negedge clkin);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_pll_reset", 32'(pll_reset), 32'd1);
      check("rst_pll_pwrdwn", 32'(pll_pwrdwn), 32'd0);
      check("rst_sys_reset_n", 32'(sys_reset_n), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_retry", 32'(retry_cnt), 32'd0);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // power-up lock: 4-cycle reset pulse, lock 10 cycles later
      n = 0;
      while (pll_reset === 1'b1 && n < 50) begin
         n++;
         @(negedge clkin);
      end
      check("pll_reset_pulse_len", 32'(n), 32'd4);
      repeat (10) @(negedge clkin);
      pll_locked = 1'b1;
      wait_state(P_RUN, 60, cyc);
      check("lock_to_ready_cycles", 32'(cyc), 32'd11);
      check("pwrup_sys_reset_n", 32'(sys_reset_n), 32'd1);
      check("pwrup_retry", 32'(retry_cnt), 32'd0);

      // lock loss in RUN
      repeat (5) @(negedge clkin);
      pll_locked = 1'b0;
      wait_state(P_HOLD, 10, cyc);
      check("lockloss_latency", 32'(cyc), 32'(SYNC + 1));
      check("lockloss_ready", 32'(ready), 32'd0);
      repeat (6) @(negedge clkin);
      pll_locked = 1'b1;
      wait_state(P_RUN, 200, cyc);
      check("relock_retry", 32'(retry_cnt), 32'd1);

      // power-down from RUN for 20 cycles
      pwrdwn_req = 1'b1;
      @(negedge clkin);
      check("pd_pll_pwrdwn", 32'(pll_pwrdwn), 32'd1);
      check("pd_pll_reset", 32'(pll_reset), 32'd1);
      check("pd_ready", 32'(ready), 32'd0);
      repeat (19) @(negedge clkin);
      pwrdwn_req = 1'b0;
      wait_state(P_HOLD, 5, cyc);
      n = 0;
      while (state_o == 3'(P_HOLD) && n < 50) begin
         n++;
         @(negedge clkin);
      end
      check("pd_hold_len", 32'(n), 32'd4);
      wait_state(P_RUN, 200, cyc);
      check("pd_retry_kept", 32'(retry_cnt), 32'd1);

      // single-cycle lock glitch inside STABLE
      pulse_restart(1'b0);
      wait_state(P_STABLE, 100, cyc);
      repeat (3) @(negedge clkin);
      pll_locked = 1'b0;
      @(negedge clkin);
      pll_locked = 1'b1;
      wait_state(P_HOLD, 10, cyc);
      check("glitch_retry", 32'(retry_cnt), 32'd1);
      wait_state(P_STABLE, 100, cyc);
      n = 0;
      while (state_o == 3'(P_STABLE) && n < 50) begin
         n++;
         @(negedge clkin);
      end
      check("glitch_full_window", 32'(n), 32'(STB_C));
      check("glitch_ready", 32'(ready), 32'd1);

      // lock never arrives: three timeouts then FAULT
      pll_locked = 1'b0;
      pulse_restart(1'b0);
      wait_state(P_FAULT, 400, cyc);
      check("timeout_to_fault", 32'(cyc), 32'(3 * (HOLD_C + TMO_C)));
      check("fault_retry", 32'(retry_cnt), 32'd3);
      repeat (30) @(negedge clkin);
      check("fault_sticky", 32'(fault), 32'd1);
      check("fault_pll_reset", 32'(pll_reset), 32'd1);

      // restart coincident with power-down request leaves FAULT into PWRDN
      pulse_restart(1'b1);
      check("rs_pd_state", 32'(state_o), 32'(P_PWRDN));
      check("rs_pd_fault", 32'(fault), 32'd0);
      check("rs_pd_retry", 32'(retry_cnt), 32'd0);
      repeat (5) @(negedge clkin);
      pwrdwn_req = 1'b0;
      pll_locked = 1'b1;
      wait_state(P_STABLE, 100, cyc);
      repeat (2) @(negedge clkin);

      // asynchronous reset mid-STABLE, sampled before any clock edge
      @(posedge clkin);
      #1;
      reset_n = 1'b0;
      #1;
      check("async_state", 32'(state_o), 32'd0);
      check("async_pll_reset", 32'(pll_reset), 32'd1);
      check("async_sys_reset_n", 32'(sys_reset_n), 32'd0);
      check("async_ready", 32'(ready), 32'd0);
      repeat (2) @(negedge clkin);
      reset_n = 1'b1;

      // randomized lock behaviour with occasional restart and power-down
      hold_left = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clkin);
         if (hold_left == 0) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            hold_left  = (pll_locked && $urandom_range(0, 1) == 1) ? $urandom_range(20, 150)
                                                                   : $urandom_range(1, 12);
         end else begin
            hold_left--;
         end
         restart = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 249) == 0) pwrdwn_req = ~pwrdwn_req;
      end
      restart    = 1'b0;
      pwrdwn_req = 1'b0;
      repeat (5) @(negedge clkin);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the PLLE2 wrapper from power-up to a usable clock: pulses the PLL reset, waits for LOCKED, qualifies lock stability, then releases a downstream system reset.
- Detects loss of lock and lock timeout, and re-sequences automatically with a bounded retry count.
- Runs on the raw 16 MHz board input clock, the same clock that feeds the PLL clkin. It therefore keeps working while the PLL outputs are dead.

Parameters:
- RST_HOLD_CYCLES, 16, cycles pll_reset is held high per attempt (min 1).
- LOCK_TIMEOUT_CYCLES, 16384, cycles allowed in WAIT_LOCK before the attempt is declared failed (~1 ms at 16 MHz).
- STABLE_CYCLES, 256, consecutive synchronized-locked cycles required before the system reset is released.
- MAX_RETRIES, 7, failed attempts allowed before entering FAULT (0 = no retry).
- SYNC_STAGES, 2, flip-flop stages in the pll_locked synchronizer (min 2).

Ports:
- clkin  in  1  board input clock, same net as the PLL clkin.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked output; asynchronous to clkin.
- restart  in  1  single-cycle pulse; forces a new sequence from any state, clears FAULT and the retry count.
- pwrdwn_req  in  1  level; high requests PLL power-down.
- pll_reset  out  1  drives the PLL reset input.
- pll_pwrdwn  out  1  drives the PLL pwrdwn input.
- sys_reset_n  out  1  active-low reset for logic clocked by PLL outputs; asserted asynchronously, deasserted synchronously.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  8  failed attempts since reset_n or restart; saturates at 255.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = HOLD; pll_reset = 1; pll_pwrdwn = 0; sys_reset_n = 0.
  - ready = 0; fault = 0; retry_cnt = 0; all counters = 0; synchronizer flops = 0.
- Synchronizer: locked_s is pll_locked passed through SYNC_STAGES flops. All decisions use locked_s only.
- All outputs are registered. State and outputs change on the clkin rising edge.
- HOLD (encoding 0):
  - pll_reset = 1, sys_reset_n = 0. Counter counts RST_HOLD_CYCLES cycles.
  - Then go to WAIT_LOCK, clear the counter, set pll_reset = 0.
- WAIT_LOCK (encoding 1):
  - If locked_s = 1: go to STABLE, clear the counter.
  - If the counter reaches LOCK_TIMEOUT_CYCLES-1 with locked_s = 0: the attempt fails.
- STABLE (encoding 2):
  - Counter increments while locked_s = 1.
  - If locked_s = 0: the attempt fails.
  - When the counter reaches STABLE_CYCLES-1: go to RUN, set sys_reset_n = 1 and ready = 1 in the same registered update.
- RUN (encoding 3):
  - If locked_s = 0: the attempt fails. sys_reset_n = 0 and ready = 0 on the next edge.
- Failed attempt:
  - retry_cnt increments, saturating.
  - If the attempt count since the last reset/restart exceeds MAX_RETRIES: go to FAULT.
  - Otherwise go to HOLD.
- FAULT (encoding 5):
  - pll_reset = 1, sys_reset_n = 0, fault = 1.
  - Stays until restart or reset_n.
- PWRDN (encoding 4):
  - Entered from any state except FAULT when pwrdwn_req = 1.
  - pll_pwrdwn = 1, pll_reset = 1, sys_reset_n = 0, ready = 0.
  - When pwrdwn_req falls: go to HOLD with a fresh hold count. retry_cnt is unchanged.
- Priority when events coincide: restart > pwrdwn_req > lock loss/timeout > counter completion.
  - restart goes to HOLD, clears retry_cnt, fault and counters.
  - restart while pwrdwn_req = 1 goes to PWRDN, with retry_cnt cleared.
- Lock glitch: a locked_s drop for a single cycle in STABLE restarts the whole sequence; partial stability is never credited.
- Reset mid-operation: reset_n low in any state immediately forces the reset values above.
- Width rule: counter width is $clog2 of the maximum of the three cycle parameters, plus 1. No wrap can occur because every state clears the counter on exit.

Decomposition:
- Shared package pll_seq_pkg:
  - state enum: HOLD = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3, PWRDN = 4, FAULT = 5; 3-bit state type.
  - retry counter width constant (8).
- One sub-module, sync_bit: an N-stage flop synchronizer with asynchronous active-low reset. It is used for pll_locked and reused by other clock-crossing logic.
- Counter and FSM stay in the top module.

Test Plan:
1. Power-up lock, with RST_HOLD = 4, TIMEOUT = 64, STABLE = 8, SYNC = 2; pll_locked rises 10 cycles after pll_reset falls.
   - pll_reset is high for exactly 4 cycles.
   - sys_reset_n and ready rise 2 + 8 cycles after pll_locked rises (±1 for synchronizer phase).
   - retry_cnt = 0.
2. Timeout retry, with pll_locked held at 0 and MAX_RETRIES = 2.
   - Three HOLD pulses of 4 cycles each, 64 cycles apart.
   - Then fault = 1 with retry_cnt = 3 and pll_reset = 1 permanently.
3. Lock glitch in STABLE: drop pll_locked for 1 cycle at stable count 5.
   - Returns to HOLD, retry_cnt = 1.
   - A full fresh 8-cycle STABLE window is needed before ready goes high.
4. Lock loss in RUN: deassert pll_locked.
   - sys_reset_n = 0 and ready = 0 within SYNC + 1 cycles.
   - Re-sequences; ready returns after the next full lock/stable window.
5. Power-down: pwrdwn_req = 1 in RUN for 20 cycles.
   - pll_pwrdwn = 1, pll_reset = 1, ready = 0 on the next edge.
   - After release: 4-cycle HOLD, then a normal lock; retry_cnt unchanged.
6. Priority and reset: restart in FAULT clears fault and retry_cnt and re-sequences.
   - Coincident restart and pwrdwn_req results in PWRDN.
   - reset_n low mid-STABLE forces all reset values asynchronously, without waiting for a clock edge.
